// File: rtl/cl_systolic_pkg.sv
// Shared constants and FSM state type for the systolic-array BRAM feeder.
package cl_systolic_pkg;

  localparam int DATA_SIZE        = 8;
  localparam int SYSTOLIC_SIZE    = 8;
  localparam int MEMORY_DATA_SIZE = 64;
  localparam int DEPTH            = 128;
  // Counters must hold the value DEPTH itself, not just DEPTH-1.
  localparam int CNT_W            = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cl_skew_line.sv
// Fixed-length delay line for one systolic lane; DELAY=0 is a plain wire.
module cl_skew_line #(
  parameter int data_size = 8,
  parameter int DELAY     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [data_size-1:0] d_i,
  output logic [data_size-1:0] q_o
);

  if (DELAY == 0) begin : g_wire
    logic unused_s;
    assign unused_s = clk ^ reset;
    assign q_o      = d_i;
  end else begin : g_pipe
    logic [data_size-1:0] stage_q [DELAY];

    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int j = 0; j < DELAY; j++) begin
          stage_q[j] <= {data_size{1'b0}};
        end
      end else begin
        stage_q[0] <= d_i;
        for (int j = 1; j < DELAY; j++) begin
          stage_q[j] <= stage_q[j-1];
        end
      end
    end

    assign q_o = stage_q[DELAY-1];
  end

endmodule

// File: rtl/cl_bram_feeder_a.sv
// Reads num_rows BRAM words, feeds them lane-skewed into a systolic array and
// writes the returned result words back to a second BRAM region.
module cl_bram_feeder_a
  import cl_systolic_pkg::*;
#(
  parameter int data_size        = DATA_SIZE,
  parameter int systolic_size    = SYSTOLIC_SIZE,
  parameter int memory_data_size = MEMORY_DATA_SIZE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [31:0]                 base_addr_a,
  input  logic [31:0]                 base_addr_out,
  input  logic [7:0]                  num_rows,
  output logic                        work,
  output logic                        out_in,
  output logic [31:0]                 memory_address_A,
  input  logic [memory_data_size-1:0] memory_in_a,
  output logic                        in_out,
  output logic [31:0]                 memory_address_OUT,
  output logic [memory_data_size-1:0] memory_out,
  output logic                        feed_valid,
  output logic [memory_data_size-1:0] feed_data,
  input  logic                        res_valid,
  input  logic [memory_data_size-1:0] res_data,
  output logic                        busy,
  output logic                        done
);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         n_q, n_d;
  logic [CNT_W-1:0]         rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]         w_q, w_d;
  logic [31:0]              base_out_q, base_out_d;
  logic [31:0]              addr_a_q, addr_a_d;
  logic                     out_in_q, out_in_d;
  logic                     rd_valid_q;
  logic [systolic_size-2:0] vld_sr_q;
  logic                     wr_en_s;
  logic                     cap_en_s;
  logic                     pipe_busy_s;

  // Result writes are accepted only while reading/draining and until every row is written.
  assign wr_en_s  = reset && res_valid && ((state_q == READ) || (state_q == DRAIN)) && (w_q < n_q);
  assign cap_en_s = reset && rd_valid_q;

  assign pipe_busy_s = rd_valid_q | (|vld_sr_q);

  // State, job parameters and the read/write bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      n_q        <= {CNT_W{1'b0}};
      rd_idx_q   <= {CNT_W{1'b0}};
      w_q        <= {CNT_W{1'b0}};
      base_out_q <= 32'd0;
      addr_a_q   <= 32'd0;
      out_in_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      vld_sr_q   <= {(systolic_size-1){1'b0}};
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      rd_idx_q   <= rd_idx_d;
      w_q        <= w_d;
      base_out_q <= base_out_d;
      addr_a_q   <= addr_a_d;
      out_in_q   <= out_in_d;
      rd_valid_q <= out_in_q;
      vld_sr_q   <= {vld_sr_q[systolic_size-3:0], rd_valid_q};
    end
  end

  // Next-state logic; read address/enable are computed one cycle ahead so they leave a flop.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    rd_idx_d   = rd_idx_q;
    w_d        = w_q + {{(CNT_W-1){1'b0}}, wr_en_s};
    base_out_d = base_out_q;
    addr_a_d   = addr_a_q;
    out_in_d   = out_in_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d        = num_rows;
          base_out_d = base_addr_out;
          w_d        = {CNT_W{1'b0}};
          rd_idx_d   = {CNT_W{1'b0}};
          if (num_rows == 8'd0) begin
            state_d = DONE;
          end else begin
            state_d  = READ;
            out_in_d = 1'b1;
            addr_a_d = base_addr_a;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (rd_idx_q == (n_q - {{(CNT_W-1){1'b0}}, 1'b1})) begin
          state_d  = DRAIN;
          out_in_d = 1'b0;
          addr_a_d = 32'd0;
        end else begin
          rd_idx_d = rd_idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
          addr_a_d = addr_a_q + 32'd1;
        end
      end
      DRAIN: begin
        if (!pipe_busy_s && (w_d == n_q)) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        out_in_d = 1'b0;
      end
    endcase
  end

  // Lane i of the captured word is delayed by i cycles to form the skew wavefront.
  for (genvar i = 0; i < systolic_size; i++) begin : g_lane
    logic [data_size-1:0] lane_in_s;
    assign lane_in_s = cap_en_s ? memory_in_a[i*data_size +: data_size] : {data_size{1'b0}};

    cl_skew_line #(
      .data_size(data_size),
      .DELAY    (i)
    ) u_skew (
      .clk  (clk),
      .reset(reset),
      .d_i  (lane_in_s),
      .q_o  (feed_data[i*data_size +: data_size])
    );
  end

  assign feed_valid         = reset && pipe_busy_s;
  assign out_in             = out_in_q;
  assign memory_address_A   = addr_a_q;
  assign in_out             = wr_en_s;
  assign memory_address_OUT = wr_en_s ? (base_out_q + {{(32-CNT_W){1'b0}}, w_q}) : 32'd0;
  assign memory_out         = wr_en_s ? res_data : {memory_data_size{1'b0}};
  assign busy               = (state_q != IDLE);
  assign work               = (state_q != IDLE);
  assign done               = (state_q == DONE);

endmodule

// File: tb/tb_cl_bram_feeder_a.sv
// Directed self-checking bench for cl_bram_feeder_a.
module tb_cl_bram_feeder_a;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr_a;
  logic [31:0] base_addr_out;
  logic [7:0]  num_rows;
  logic        work;
  logic        out_in;
  logic [31:0] memory_address_A;
  logic [63:0] memory_in_a;
  logic        in_out;
  logic [31:0] memory_address_OUT;
  logic [63:0] memory_out;
  logic        feed_valid;
  logic [63:0] feed_data;
  logic        res_valid;
  logic [63:0] res_data;
  logic        busy;
  logic        done;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [63:0] mem [0:255];

  always #5 clk = ~clk;

  cl_bram_feeder_a dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .base_addr_a       (base_addr_a),
    .base_addr_out     (base_addr_out),
    .num_rows          (num_rows),
    .work              (work),
    .out_in            (out_in),
    .memory_address_A  (memory_address_A),
    .memory_in_a       (memory_in_a),
    .in_out            (in_out),
    .memory_address_OUT(memory_address_OUT),
    .memory_out        (memory_out),
    .feed_valid        (feed_valid),
    .feed_data         (feed_data),
    .res_valid         (res_valid),
    .res_data          (res_data),
    .busy              (busy),
    .done              (done)
  );

  // Synchronous-read BRAM model: data one cycle after the enable.
  always @(posedge clk) begin
    if (out_in) memory_in_a <= mem[memory_address_A[7:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle; returns in cycle T+1.
  task automatic launch(input logic [31:0] a, input logic [31:0] o, input logic [7:0] n);
    base_addr_a   = a;
    base_addr_out = o;
    num_rows      = n;
    start         = 1'b1;
    tick();
    start         = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    res_valid = 1'b1;
    res_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    vec_cnt++;
    if ({busy, done, work, out_in, in_out, feed_valid} !== 6'b0) begin
      err_cnt++;
      $display("FAIL reset_ctrl got %b want 000000", {busy, done, work, out_in, in_out, feed_valid});
    end
    vec_cnt++;
    if ({feed_data, memory_out, memory_address_A, memory_address_OUT} !== 192'd0) begin
      err_cnt++;
      $display("FAIL reset_data got %h/%h/%h/%h want zeros", feed_data, memory_out,
               memory_address_A, memory_address_OUT);
    end
    res_valid = 1'b0;
    reset     = 1'b1;
    tick();
  endtask

  // Skewed feed of two words plus early writes and a surplus third result.
  task automatic test_feed_and_write();
    logic [63:0] exp_fd;
    int          k;
    launch(32'h10, 32'h40, 8'd2);
    for (int c = 1; c <= 13; c++) begin
      res_valid = (c == 4) || (c == 6) || (c == 8);
      res_data  = (c == 4) ? 64'hAAAA_AAAA_AAAA_AAAA :
                  (c == 6) ? 64'h5555_5555_5555_5555 : 64'h3333_3333_3333_3333;
      #1;
      for (int i = 0; i < 8; i++) begin
        k = c - 2 - i;
        exp_fd[i*8 +: 8] = (k == 0) ? 8'(i + 1) : (k == 1) ? 8'(8'h11 + i) : 8'h00;
      end
      vec_cnt++;
      if (feed_data !== exp_fd) begin
        err_cnt++;
        $display("FAIL feed_data c=%0d got %h want %h", c, feed_data, exp_fd);
      end
      vec_cnt++;
      if (feed_valid !== ((c >= 2) && (c <= 10))) begin
        err_cnt++;
        $display("FAIL feed_valid c=%0d got %b", c, feed_valid);
      end
      vec_cnt++;
      if (out_in !== ((c == 1) || (c == 2))) begin
        err_cnt++;
        $display("FAIL out_in c=%0d got %b", c, out_in);
      end
      if ((c == 1) || (c == 2)) begin
        vec_cnt++;
        if (memory_address_A !== 32'h10 + 32'(c - 1)) begin
          err_cnt++;
          $display("FAIL addr_a c=%0d got %h want %h", c, memory_address_A, 32'h10 + 32'(c - 1));
        end
      end
      vec_cnt++;
      if (in_out !== ((c == 4) || (c == 6))) begin
        err_cnt++;
        $display("FAIL in_out c=%0d got %b", c, in_out);
      end
      if ((c == 4) || (c == 6)) begin
        vec_cnt++;
        if ({memory_address_OUT, memory_out} !== {((c == 4) ? 32'h40 : 32'h41), res_data}) begin
          err_cnt++;
          $display("FAIL write c=%0d got %h:%h want %h:%h", c, memory_address_OUT, memory_out,
                   (c == 4) ? 32'h40 : 32'h41, res_data);
        end
      end
      vec_cnt++;
      if ({done, busy, work} !== {(c == 12), (c <= 12), (c <= 12)}) begin
        err_cnt++;
        $display("FAIL status c=%0d got done/busy/work %b%b%b", c, done, busy, work);
      end
      tick();
    end
    res_valid = 1'b0;
  endtask

  // Writes arrive after the pipeline drained: done follows the last write.
  task automatic test_late_writes();
    launch(32'h10, 32'h40, 8'd2);
    for (int c = 1; c <= 16; c++) begin
      res_valid = (c == 12) || (c == 14);
      res_data  = (c == 12) ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h5555_5555_5555_5555;
      #1;
      vec_cnt++;
      if (in_out !== ((c == 12) || (c == 14))) begin
        err_cnt++;
        $display("FAIL late_in_out c=%0d got %b", c, in_out);
      end
      if ((c == 12) || (c == 14)) begin
        vec_cnt++;
        if ({memory_address_OUT, memory_out} !== {((c == 12) ? 32'h40 : 32'h41), res_data}) begin
          err_cnt++;
          $display("FAIL late_write c=%0d got %h:%h", c, memory_address_OUT, memory_out);
        end
      end
      vec_cnt++;
      if ({done, busy} !== {(c == 15), (c <= 15)}) begin
        err_cnt++;
        $display("FAIL late_status c=%0d got done/busy %b%b", c, done, busy);
      end
      tick();
    end
    res_valid = 1'b0;
  endtask

  // Empty job goes straight to DONE; results in DONE and IDLE are dropped.
  task automatic test_zero_rows();
    launch(32'h10, 32'h40, 8'd0);
    res_valid = 1'b1;
    res_data  = 64'h1234_5678_9ABC_DEF0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      vec_cnt++;
      if ({done, busy, out_in, in_out, feed_valid} !== {(c == 1), (c == 1), 3'b000}) begin
        err_cnt++;
        $display("FAIL zero_rows c=%0d got done/busy/out_in/in_out/fv %b", c,
                 {done, busy, out_in, in_out, feed_valid});
      end
      tick();
    end
    res_valid = 1'b0;
  endtask

  // A second start during READ must not disturb the running job.
  task automatic test_restart_ignored();
    launch(32'h20, 32'h40, 8'd4);
    for (int c = 1; c <= 16; c++) begin
      start       = (c == 2);
      base_addr_a = 32'h99;
      num_rows    = 8'd7;
      res_valid   = (c >= 5) && (c <= 8);
      res_data    = 64'(c);
      #1;
      vec_cnt++;
      if (out_in !== ((c >= 1) && (c <= 4))) begin
        err_cnt++;
        $display("FAIL rs_out_in c=%0d got %b", c, out_in);
      end
      if ((c >= 1) && (c <= 4)) begin
        vec_cnt++;
        if (memory_address_A !== 32'h20 + 32'(c - 1)) begin
          err_cnt++;
          $display("FAIL rs_addr_a c=%0d got %h want %h", c, memory_address_A, 32'h20 + 32'(c - 1));
        end
      end
      if ((c >= 5) && (c <= 8)) begin
        vec_cnt++;
        if ({in_out, memory_address_OUT} !== {1'b1, 32'h40 + 32'(c - 5)}) begin
          err_cnt++;
          $display("FAIL rs_write c=%0d got %b:%h", c, in_out, memory_address_OUT);
        end
      end
      vec_cnt++;
      if (done !== (c == 14)) begin
        err_cnt++;
        $display("FAIL rs_done c=%0d got %b", c, done);
      end
      tick();
    end
    start     = 1'b0;
    res_valid = 1'b0;
  endtask

  // Reset in DRAIN abandons the job; the next one-row job runs cleanly.
  task automatic test_reset_mid_job();
    logic [63:0] exp_fd;
    launch(32'h10, 32'h40, 8'd2);
    tick();
    tick();
    tick();
    reset     = 1'b0;
    res_valid = 1'b1;
    res_data  = 64'hFFFF_0000_FFFF_0000;
    #1;
    vec_cnt++;
    if (in_out !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_mid_write got in_out %b want 0", in_out);
    end
    tick();
    vec_cnt++;
    if ({busy, done, work, out_in, in_out, feed_valid, feed_data, memory_out,
         memory_address_A, memory_address_OUT} !== 198'd0) begin
      err_cnt++;
      $display("FAIL rst_mid_outputs got busy=%b fv=%b fd=%h mo=%h", busy, feed_valid,
               feed_data, memory_out);
    end
    reset     = 1'b1;
    res_valid = 1'b0;
    tick();
    launch(32'h11, 32'h50, 8'd1);
    for (int c = 1; c <= 12; c++) begin
      res_valid = (c == 3);
      res_data  = 64'hAAAA_AAAA_AAAA_AAAA;
      #1;
      for (int i = 0; i < 8; i++) begin
        exp_fd[i*8 +: 8] = (c - 2 == i) ? 8'(8'h11 + i) : 8'h00;
      end
      vec_cnt++;
      if (feed_data !== exp_fd) begin
        err_cnt++;
        $display("FAIL rj_feed c=%0d got %h want %h", c, feed_data, exp_fd);
      end
      vec_cnt++;
      if ({out_in, feed_valid, in_out, done} !==
          {(c == 1), ((c >= 2) && (c <= 9)), (c == 3), (c == 11)}) begin
        err_cnt++;
        $display("FAIL rj_ctrl c=%0d got out_in/fv/in_out/done %b", c,
                 {out_in, feed_valid, in_out, done});
      end
      if (c == 3) begin
        vec_cnt++;
        if ({memory_address_OUT, memory_out} !== {32'h50, 64'hAAAA_AAAA_AAAA_AAAA}) begin
          err_cnt++;
          $display("FAIL rj_write got %h:%h want 00000050:aaaaaaaaaaaaaaaa", memory_address_OUT,
                   memory_out);
        end
      end
      tick();
    end
    res_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[a] = {32'hC0DE_0000 + 32'(a), 32'h5A5A_0000 + 32'(a)};
    end
    mem[8'h10]    = 64'h0807_0605_0403_0201;
    mem[8'h11]    = 64'h1817_1615_1413_1211;
    memory_in_a   = 64'hDEAD_BEEF_CAFE_F00D;
    reset         = 1'b0;
    start         = 1'b0;
    base_addr_a   = 32'd0;
    base_addr_out = 32'd0;
    num_rows      = 8'd0;
    res_valid     = 1'b0;
    res_data      = 64'd0;
    test_reset();
    test_feed_and_write();
    test_late_writes();
    test_zero_rows();
    test_restart_ignored();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
